// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_pkg                                                          |
// | Brief    : Shared AES block type, round constants and controller FSM enum.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR128 = 10;
    localparam int AES_FSM_W = 2;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [AES_FSM_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } aes_fsm_t;

endpackage
`default_nettype wire

// File: rtl/aes_round_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_round_cnt                                                    |
// | Brief    : Round counter (4 bit, saturates at NR) and datapath-latency      |
// |            wait counter (3 bit) for the AES round controller.               |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_round_cnt #(
    parameter int DP_LAT = 3,
    parameter int NR     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_round_init,
    input  logic       i_round_inc,
    input  logic       i_cnt_init,
    input  logic       i_cnt_inc,
    output logic [3:0] o_round,
    output logic       o_cnt_done,
    output logic       o_round_last
);

    localparam logic [3:0] c_NR     = 4'(NR);
    localparam logic [2:0] c_DP_LAT = 3'(DP_LAT);

    logic [3:0] r_round;
    logic [2:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_round <= 4'd0;
            r_cnt   <= 3'd0;
        end else begin
            if (i_round_init) begin
                r_round <= 4'd1;
            end else if (i_round_inc && (r_round < c_NR)) begin
                r_round <= r_round + 4'd1;
            end
            // Wait counter parks at zero once the datapath result is taken.
            if (i_cnt_init) begin
                r_cnt <= 3'd1;
            end else if (i_cnt_inc) begin
                r_cnt <= (r_cnt == c_DP_LAT) ? 3'd0 : r_cnt + 3'd1;
            end
        end
    end

    assign o_round      = r_round;
    assign o_cnt_done   = (r_cnt == c_DP_LAT);
    assign o_round_last = (r_round == c_NR);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_round_ctrl                                                   |
// | Brief    : Iterative AES encryption round controller driving an external   |
// |            round datapath and key store. Optional abort input enabled by    |
// |            macro AES_ROUND_CTRL_ABORT_EN.                                   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DP_LAT = 3,
    parameter int NR     = AES_NR128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic [3:0]           rk_idx,
    input  logic [AES_BLK_W-1:0] rk_in,
    output logic                 dp_start,
    output logic                 dp_last,
    output logic [AES_BLK_W-1:0] dp_in,
    input  logic [AES_BLK_W-1:0] dp_out,
    output logic                 busy
`ifdef AES_ROUND_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    aes_fsm_t   r_fsm;
    aes_fsm_t   w_fsm_nxt;
    aes_blk_t   r_state_q;

    logic       w_abort;
    logic       w_accept;
    logic       w_capture;
    logic       w_clr;
    logic       w_round_init;
    logic       w_round_inc;
    logic       w_cnt_init;
    logic       w_cnt_inc;
    logic       w_cnt_done;
    logic       w_round_last;
    logic [3:0] w_round;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    aes_round_cnt #(
        .DP_LAT (DP_LAT),
        .NR     (NR)
    ) u_round_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_round_init (w_round_init),
        .i_round_inc  (w_round_inc),
        .i_cnt_init   (w_cnt_init),
        .i_cnt_inc    (w_cnt_inc),
        .o_round      (w_round),
        .o_cnt_done   (w_cnt_done),
        .o_round_last (w_round_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt    = r_fsm;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        dp_start     = 1'b0;
        dp_last      = 1'b0;
        rk_idx       = 4'd0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_clr        = 1'b0;
        w_round_init = 1'b0;
        w_round_inc  = 1'b0;
        w_cnt_init   = 1'b0;
        w_cnt_inc    = 1'b0;

        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_round_init = 1'b1;
                    w_fsm_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                dp_start   = 1'b1;
                rk_idx     = w_round;
                dp_last    = w_round_last;
                w_cnt_init = 1'b1;
                w_fsm_nxt  = WAIT;
            end
            WAIT: begin
                // Round index only advances on the exit edge, so rk_idx/dp_last hold all round.
                rk_idx    = w_round;
                dp_last   = w_round_last;
                w_cnt_inc = 1'b1;
                if (w_cnt_done) begin
                    w_capture = 1'b1;
                    if (w_round_last) begin
                        w_fsm_nxt = DONE;
                    end else begin
                        w_round_inc = 1'b1;
                        w_fsm_nxt   = ISSUE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                rk_idx    = w_round;
                if (out_ready) begin
                    w_clr     = 1'b1;
                    w_fsm_nxt = IDLE;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase

        // Abort drops the block in flight but leaves state_q as it was.
        if (w_abort && (r_fsm != IDLE)) begin
            w_fsm_nxt   = IDLE;
            w_clr       = 1'b1;
            w_capture   = 1'b0;
            w_round_inc = 1'b0;
            w_cnt_init  = 1'b0;
            w_cnt_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= '0;
        end else if (w_accept) begin
            r_state_q <= in_data ^ rk_in;
        end else if (w_capture) begin
            r_state_q <= dp_out;
        end
    end

    assign dp_in    = r_state_q;
    assign out_data = r_state_q;
    assign busy     = (r_fsm != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_round_ctrl                                                |
// | Brief    : Bench for aes_round_ctrl with behavioural AES round datapath,    |
// |            key store and whole-cipher reference model.                      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int c_DP_LAT = 3;
    localparam int c_NR     = 10;
    localparam int c_LAT    = 1 + c_NR * (c_DP_LAT + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    aes_blk_t   in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    aes_blk_t   out_data;
    logic [3:0] rk_idx;
    aes_blk_t   rk_in;
    logic       dp_start;
    logic       dp_last;
    aes_blk_t   dp_in;
    aes_blk_t   dp_out;
    logic       busy;
    logic       abort = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int start_snap = 0;
    int bad_last = 0;
    logic [3:0] rk_q [$];

    logic [7:0] sbox_t [256];
    aes_blk_t   rk_arr [16];
    aes_blk_t   dp_pipe [c_DP_LAT];

    always #5 clk = ~clk;

    aes_round_ctrl #(
        .DP_LAT (c_DP_LAT),
        .NR     (c_NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .dp_start  (dp_start),
        .dp_last   (dp_last),
        .dp_in     (dp_in),
        .dp_out    (dp_out),
        .busy      (busy)
`ifdef AES_ROUND_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic aes_blk_t aes_round(input aes_blk_t s, input aes_blk_t rk, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m0, m1, m2, m3;
        aes_blk_t   o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
            if (last) begin
                a[4*c] = m0; a[4*c+1] = m1; a[4*c+2] = m2; a[4*c+3] = m3;
            end else begin
                a[4*c]   = gmul(m0, 8'h02) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
                a[4*c+1] = m0 ^ gmul(m1, 8'h02) ^ gmul(m2, 8'h03) ^ m3;
                a[4*c+2] = m0 ^ m1 ^ gmul(m2, 8'h02) ^ gmul(m3, 8'h03);
                a[4*c+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ gmul(m3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
        return o ^ rk;
    endfunction

    function automatic aes_blk_t ref_enc(input aes_blk_t pt);
        aes_blk_t s = pt ^ rk_arr[0];
        for (int r = 1; r <= c_NR; r++) s = aes_round(s, rk_arr[r], r == c_NR);
        return s;
    endfunction

    task automatic set_key(input aes_blk_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= c_NR) rk_arr[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else           rk_arr[r] = '0;
        end
    endtask

    // Key store and fixed-latency round datapath.
    assign rk_in  = rk_arr[rk_idx];
    assign dp_out = dp_pipe[c_DP_LAT-1];

    always @(posedge clk) begin
        dp_pipe[0] <= dp_start ? aes_round(dp_in, rk_in, dp_last) : '0;
        for (int i = 1; i < c_DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (dp_start) begin
                n_start++;
                rk_q.push_back(rk_idx);
            end
            if (dp_last && (rk_idx != 4'(c_NR))) bad_last++;
            if (dp_start && ((rk_idx == 4'(c_NR)) != dp_last)) bad_last++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic aes_blk_t rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_block(input aes_blk_t pt);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = pt;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'(1));
        chk("rk_idx_idle", 128'(rk_idx), 128'(0));
        start_snap = n_start;
        rk_q.delete();
        bad_last = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rnd_blk();
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_wait", 128'(out_valid), 128'(1));
    endtask

    task automatic check_block(input string tag, input aes_blk_t exp, input int lat);
        logic [127:0] got_seq = '0;
        logic [127:0] exp_seq = '0;
        foreach (rk_q[i]) got_seq = {got_seq[123:0], rk_q[i]};
        for (int r = 1; r <= c_NR; r++) exp_seq = {exp_seq[123:0], 4'(r)};
        chk({tag, "_ct"}, out_data, exp);
        chk({tag, "_lat"}, 128'(lat), 128'(c_LAT));
        chk({tag, "_nstart"}, 128'(n_start - start_snap), 128'(c_NR));
        chk({tag, "_rkseq"}, got_seq, exp_seq);
        chk({tag, "_dplast"}, 128'(bad_last), 128'(0));
    endtask

    initial begin
        aes_blk_t pt, pt2, exp, exp2, hold;
        int       lat;
        logic     ok;

        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int k = 1; k < 256; k++) if (gmul(8'(v), 8'(k)) == 8'h01) inv = 8'(k);
            sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int r = 0; r < 16; r++) rk_arr[r] = '0;

        // Reset with in_valid asserted: reset must win over the handshake.
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_dp_start", 128'(dp_start), 128'(0));
        chk("rst_dp_last", 128'(dp_last), 128'(0));
        chk("rst_state", out_data, 128'(0));
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 appendix C.1 vector.
        set_key(128'h000102030405060708090a0b0c0d0e0f);
        pt = 128'h00112233445566778899aabbccddeeff;
        chk("fips_model", ref_enc(pt), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        out_ready = 1'b1;
        start_block(pt);
        wait_out(lat);
        check_block("fips", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat);
        @(posedge clk); #1;

        // Back-to-back blocks with a random key.
        set_key(rnd_blk());
        pt   = rnd_blk();
        pt2  = rnd_blk();
        exp  = ref_enc(pt);
        exp2 = ref_enc(pt2);
        start_block(pt);
        wait_out(lat);
        check_block("b2b_a", exp, lat);
        in_valid = 1'b1;
        in_data  = pt2;
        chk("b2b_ready_in_done", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        chk("b2b_ready_after", 128'(in_ready), 128'(1));
        chk("b2b_outv_after", 128'(out_valid), 128'(0));
        start_block(pt2);
        wait_out(lat);
        check_block("b2b_b", exp2, lat);
        @(posedge clk); #1;

        // Consumer stall in DONE.
        out_ready = 1'b0;
        pt  = rnd_blk();
        exp = ref_enc(pt);
        start_block(pt);
        wait_out(lat);
        check_block("stall", exp, lat);
        hold = out_data;
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!out_valid || (out_data !== hold)) ok = 1'b0;
        end
        chk("stall_stable", 128'(ok), 128'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_busy", 128'(busy), 128'(0));
        chk("stall_release_ready", 128'(in_ready), 128'(1));

        // Reset during round 5 WAIT (cycles 18..20 after accept).
        pt = rnd_blk();
        start_block(pt);
        repeat (17) begin @(posedge clk); #1; end
        chk("mid_rk_idx", 128'(rk_idx), 128'(5));
        chk("mid_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_outv", 128'(out_valid), 128'(0));
        rst = 1'b0;
        ok = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        chk("mid_rst_no_out", 128'(ok), 128'(1));
        pt  = rnd_blk();
        exp = ref_enc(pt);
        start_block(pt);
        wait_out(lat);
        check_block("post_rst", exp, lat);
        @(posedge clk); #1;

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort during round 3 WAIT: back to IDLE, state_q frozen, no output.
        pt = rnd_blk();
        start_block(pt);
        repeat (9) begin @(posedge clk); #1; end
        chk("abort_rk_idx", 128'(rk_idx), 128'(3));
        hold  = out_data;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ready", 128'(in_ready), 128'(1));
        chk("abort_state", out_data, hold);
        ok = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        chk("abort_no_out", 128'(ok), 128'(1));
`endif

        // A few more random keys and blocks.
        for (int n = 0; n < 3; n++) begin
            set_key(rnd_blk());
            pt  = rnd_blk();
            exp = ref_enc(pt);
            start_block(pt);
            wait_out(lat);
            check_block("rand", exp, lat);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameters SHALL be:
- DP_LAT, default 3, round-datapath latency in cycles (1..7).
- NR, default 10, number of rounds.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  block accepted when in_valid & in_ready.
- in_data  in  128  plaintext.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext.
- rk_idx  out  4  round-key index presented to key store.
- rk_in  in  128  round key for rk_idx, valid combinationally.
- dp_start  out  1  one-cycle issue pulse to round datapath.
- dp_last  out  1  final round; datapath bypasses MixColumns.
- dp_in  out  128  state fed to datapath (always state_q).
- dp_out  in  128  datapath result, valid DP_LAT cycles after dp_start.
- busy  out  1  high in any state except IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE: in_ready=1, rk_idx=0; on accept, state_q <= in_data ^ rk_in, round <= 1, next ISSUE.
REQ-005 ISSUE: dp_start=1, rk_idx=round, dp_last=(round==NR); wait counter <= 1; next WAIT.
REQ-006 WAIT: counter increments; when counter==DP_LAT, state_q <= dp_out.
- If round==NR, next DONE.
- Else round <= round+1, next ISSUE.
REQ-007 rk_idx and dp_last SHALL stay stable from ISSUE through the end of WAIT for that round.
REQ-008 DONE: out_valid=1, out_data=state_q held stable; on out_ready, next IDLE.
REQ-009 out_valid SHALL first assert exactly 1+NR*(DP_LAT+1) cycles after the accept cycle (41 at defaults).
REQ-010 in_ready SHALL be 0 outside IDLE; a new block SHALL be accepted in the cycle after the DONE handshake, not the same cycle.
REQ-011 in_valid deasserting or in_data changing after accept SHALL have no effect.
REQ-012 out_ready held low SHALL stall indefinitely in DONE with no output change.
REQ-013 The round counter SHALL be 4 bits and SHALL never exceed NR; DP_LAT counter width SHALL be 3 bits.

Reset
REQ-014 rst SHALL force, at the next edge:
- state IDLE, round 0, counter 0, state_q 0;
- in_ready 1, out_valid 0, dp_start 0, dp_last 0, busy 0.
REQ-015 rst mid-operation SHALL discard the block in flight with no out_valid pulse; rst SHALL take priority over all handshakes.

Configuration
REQ-016 Macro AES_ROUND_CTRL_ABORT_EN SHALL govern an abort input.
- Defined: adds input abort (1 bit); abort=1 in ISSUE, WAIT or DONE returns the FSM to IDLE next edge, keeps state_q unchanged and asserts no out_valid; abort in IDLE is ignored.
- Undefined: no abort port, and behaviour is identical to abort tied 0.

Structure
REQ-017 A shared package aes_pkg SHALL hold:
- the FSM state enum;
- constants AES_BLK_W=128, AES_NR128=10;
- type aes_blk_t.
REQ-018 The wait/round counter pair SHALL be a sub-module aes_round_cnt; the FSM and state_q register stay in aes_round_ctrl.

Verification
REQ-019 Bench SHALL pair the block with a behavioural round datapath (DP_LAT=3) and key store, and cover:
- FIPS-197 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 41.
- Two back-to-back blocks with out_ready=1 -> second accept one cycle after first DONE handshake; both ciphertexts correct.
- out_ready low 20 cycles in DONE -> out_valid and out_data stable; release -> IDLE next cycle.
- rst pulse in round 5 WAIT -> next cycle busy=0, in_ready=1, no out_valid; following block encrypts correctly.
- dp_start count per block = 10; dp_last high only with rk_idx=10; rk_idx sequence 0,1..10.
- With AES_ROUND_CTRL_ABORT_EN: abort in round 3 -> IDLE next cycle, no out_valid.
